// File: rtl/ahb_apb3_bridge_mslv.sv
// AHB-Lite slave to multi-slave APB3 master bridge.
// Decodes the APB target slot from HADDR, runs one APB3 SETUP/ACCESS cycle per AHB
// transfer, muxes the selected slave's PRDATA/PREADY/PSLVERR, and aborts with a
// two-cycle AHB ERROR when the slave errors, the slot is unpopulated, or the
// slave holds PREADY low for TIMEOUT ACCESS cycles.
module ahb_apb3_bridge_mslv #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_AW  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        HSEL,
    input  logic [ADDR_W-1:0]           HADDR,
    input  logic [1:0]                  HTRANS,
    input  logic                        HWRITE,
    input  logic [DATA_W-1:0]           HWDATA,
    input  logic                        HREADY,
    output logic [DATA_W-1:0]           HRDATA,
    output logic                        HREADYOUT,
    output logic [1:0]                  HRESP,
    output logic [ADDR_W-1:0]           PADDR,
    output logic [NUM_SLV-1:0]          PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [DATA_W-1:0]           PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]          PREADY,
    input  logic [NUM_SLV-1:0]          PSLVERR,
    output logic                        TMO_ERR
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LP_CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [4:0] LP_NUM_SLV = 5'(NUM_SLV);
    localparam logic [1:0] LP_OKAY  = 2'b00;
    localparam logic [1:0] LP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_haddr;
    logic                  r_hwrite;
    logic [4:0]            r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_hrdata;
    logic                  r_hreadyout;
    logic [1:0]            r_hresp;
    logic [ADDR_W-1:0]     r_paddr;
    logic [NUM_SLV-1:0]    r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [DATA_W-1:0]     r_pwdata;
    logic                  r_tmo_err;

    logic                  w_accept;
    logic [4:0]            w_idx;
    logic [DATA_W-1:0]     w_sel_rdata;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [NUM_SLV-1:0]    w_psel_nxt;
    logic                  w_tmo;
    // HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY; acceptance needs bit 1 alone.
    logic                  w_unused_htrans0;

    assign w_unused_htrans0 = HTRANS[0];
    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_tmo    = (TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

    generate
        if (NUM_SLV > 1) begin : g_idx
            assign w_idx = 5'(HADDR[SLV_AW +: IDX_W]);
        end else begin : g_idx0
            assign w_idx = '0;
        end
    endgenerate

    // Select the addressed slave's response and build its one-hot PSEL
    always_comb begin
        w_sel_rdata = '0;
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_psel_nxt  = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (r_idx == 5'(i)) begin
                w_sel_rdata   = PRDATA[i*DATA_W +: DATA_W];
                w_sel_ready   = PREADY[i];
                w_sel_err     = PSLVERR[i];
                w_psel_nxt[i] = 1'b1;
            end
        end
    end

    // Bridge FSM with all AHB and APB outputs registered
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_hrdata    <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= LP_OKAY;
            r_paddr     <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_tmo_err   <= 1'b0;
        end else begin
            r_tmo_err <= 1'b0;
            unique case (r_state)
                // IDLE, RESP and ERR2 all present HREADYOUT=1 and may take a new transfer
                ST_IDLE, ST_RESP, ST_ERR2: begin
                    r_hresp <= LP_OKAY;
                    if (w_accept) begin
                        r_haddr     <= HADDR;
                        r_hwrite    <= HWRITE;
                        r_idx       <= w_idx;
                        r_hreadyout <= 1'b0;
                        r_state     <= ST_LATCH;
                    end else begin
                        r_hreadyout <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_LATCH: begin
                    r_pwdata <= HWDATA;
                    if (r_idx >= LP_NUM_SLV) begin
                        r_hresp <= LP_ERROR;
                        r_state <= ST_ERR1;
                    end else begin
                        r_psel   <= w_psel_nxt;
                        r_paddr  <= r_haddr;
                        r_pwrite <= r_hwrite;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_sel_ready) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_cnt     <= '0;
                        if (w_sel_err) begin
                            r_hresp <= LP_ERROR;
                            r_state <= ST_ERR1;
                        end else begin
                            r_hreadyout <= 1'b1;
                            r_state     <= ST_RESP;
                            if (!r_pwrite) begin
                                r_hrdata <= w_sel_rdata;
                            end
                        end
                    end else if (w_tmo) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_cnt     <= '0;
                        r_hresp   <= LP_ERROR;
                        r_tmo_err <= 1'b1;
                        r_state   <= ST_ERR1;
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ERR1: begin
                    r_hreadyout <= 1'b1;
                    r_state     <= ST_ERR2;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign HRDATA    = r_hrdata;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign TMO_ERR   = r_tmo_err;

endmodule
